// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame controller (START/DATA/PARITY/STOP sequencing, error pulses); define PARITY_CHECK_EN to enable parity checking
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_sample_en,
    output logic [4:0]            edge_count,
    output logic [3:0]            bit_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_CHECK_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t                state, state_n;
    logic [4:0]            p_last, p_last_n, edge_n;
    logic [3:0]            bit_n;
    logic [DATA_WIDTH-1:0] shift, shift_n, pdata_n;
    logic                  dv_n, se_n, dse_n, armed, armed_n, last, go, launch, fail;
`ifdef PARITY_CHECK_EN
    logic                  par_en_q, par_typ_q, par_fail, par_en_n, par_typ_n, par_fail_n, pe_n;
    assign fail = par_fail;
`else
    logic                  unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
    assign fail       = 1'b0;
    assign par_err    = 1'b0;
`endif
    assign last = edge_count == p_last;
    // armed blocks a start until the line has been seen high since reset
    assign go   = armed & ~RX_IN;

    // frame sequencing; a low line at the end of the stop bit is the next start bit
    always_comb begin
        state_n  = state;
        edge_n   = (state == IDLE || last) ? 5'd0 : edge_count + 5'd1;
        bit_n    = bit_count;
        shift_n  = shift;
        pdata_n  = P_DATA;
        dv_n     = 1'b0;
        se_n     = 1'b0;
        armed_n  = armed | RX_IN;
        launch   = 1'b0;
        p_last_n = p_last;
`ifdef PARITY_CHECK_EN
        par_en_n   = par_en_q;
        par_typ_n  = par_typ_q;
        par_fail_n = par_fail;
        pe_n       = 1'b0;
`endif
        case (state)
            IDLE: begin
                bit_n  = 4'd0;
                launch = go;
            end
            START: if (last) begin
                state_n = sampled_bit ? IDLE : DATA;
                bit_n   = 4'd0;
            end
            DATA: if (last) begin
                shift_n = {sampled_bit, shift[DATA_WIDTH-1:1]};
                bit_n   = bit_count + 4'd1;
                if (bit_count == 4'(DATA_WIDTH - 1))
`ifdef PARITY_CHECK_EN
                    state_n = par_en_q ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
            end
`ifdef PARITY_CHECK_EN
            PARITY: if (last) begin
                par_fail_n = (^shift ^ par_typ_q) != sampled_bit;
                state_n    = STOP;
            end
`endif
            STOP: if (last) begin
                state_n = IDLE;
                bit_n   = 4'd0;
                se_n    = ~sampled_bit;
                dv_n    = sampled_bit & ~fail;
                pdata_n = (sampled_bit & ~fail) ? shift : P_DATA;
`ifdef PARITY_CHECK_EN
                pe_n    = fail;
`endif
                launch  = go;
            end
            default: state_n = IDLE;
        endcase
        if (launch) begin
            state_n  = START;
            p_last_n = (Prescale == 6'd8) ? 5'd7 : (Prescale == 6'd32) ? 5'd31 : 5'd15;
`ifdef PARITY_CHECK_EN
            par_en_n   = PAR_EN;
            par_typ_n  = PAR_TYP;
            par_fail_n = 1'b0;
`endif
        end
        dse_n = state_n != IDLE;
    end

    // state, latched config and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            edge_count     <= 5'd0;
            bit_count      <= 4'd0;
            shift          <= '0;
            P_DATA         <= '0;
            data_valid     <= 1'b0;
            stp_err        <= 1'b0;
            data_sample_en <= 1'b0;
            armed          <= 1'b0;
            p_last         <= 5'd0;
`ifdef PARITY_CHECK_EN
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_fail       <= 1'b0;
            par_err        <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            edge_count     <= edge_n;
            bit_count      <= bit_n;
            shift          <= shift_n;
            P_DATA         <= pdata_n;
            data_valid     <= dv_n;
            stp_err        <= se_n;
            data_sample_en <= dse_n;
            armed          <= armed_n;
            p_last         <= p_last_n;
`ifdef PARITY_CHECK_EN
            par_en_q       <= par_en_n;
            par_typ_q      <= par_typ_n;
            par_fail       <= par_fail_n;
            par_err        <= pe_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table-driven frame bench with a pulse scoreboard for uart_rx_ctrl
module tb_uart_rx_ctrl;
`ifdef PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif
    typedef struct {
        logic [5:0] pre;
        bit         pen;
        bit         ptyp;
        logic [7:0] d;
        bit         pbit;
        bit         stop;
        bit         xdv;
        bit         xpe;
        bit         xse;
    } vec_t;
    typedef struct {
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd16;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit = 1'b1;
    logic       data_sample_en, data_valid, par_err, stp_err;
    logic [4:0] edge_count;
    logic [3:0] bit_count;
    logic [7:0] P_DATA;

    int         n_cmp = 0;
    int         n_err = 0;
    longint     cyc = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;
    bit         prev_pulse = 1'b0;
    vec_t       vecs[7];

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_sample_en(data_sample_en),
        .edge_count(edge_count), .bit_count(bit_count), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int peff(input logic [5:0] pre);
        return (pre == 6'd8) ? 8 : (pre == 6'd32) ? 32 : 16;
    endfunction

    // every output pulse is matched against the oldest expected frame result
    always @(negedge clk) begin
        if (!rst) prev_pulse = 1'b0;
        else begin
            if (data_valid | par_err | stp_err) begin
                cmp("pulse_width", {63'd0, prev_pulse}, 64'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b, expected no pulse", data_valid, par_err, stp_err);
                end else begin
                    mon_e = sb.pop_front();
                    cmp("data_valid", {63'd0, data_valid}, {63'd0, mon_e.dv});
                    cmp("par_err", {63'd0, par_err}, {63'd0, mon_e.pe});
                    cmp("stp_err", {63'd0, stp_err}, {63'd0, mon_e.se});
                    cmp("P_DATA", {56'd0, P_DATA}, {56'd0, mon_e.pd});
                    cmp("pulse_cycle", cyc, mon_e.cyc);
                end
            end
            prev_pulse = data_valid | par_err | stp_err;
        end
    end

    // drive one frame on RX_IN; sampled_bit trails the line by one clock so it holds bit i at its decision edge
    task automatic send_frame(input logic [5:0] pre, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit pbit, input bit stop, input bit xdv, input bit xpe, input bit xse,
                              input int cut, input bit chk_ec);
        int   p;
        int   n;
        int   total;
        bit   line[12];
        exp_t e;
        p = peff(pre);
        line[0] = 1'b0;
        for (int i = 0; i < 8; i++) line[i+1] = d[i];
        n = 9;
        if (PCHK && pen) begin
            line[n] = pbit;
            n++;
        end
        line[n] = stop;
        n++;
        total = n * p;
        @(negedge clk);
        Prescale = pre;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        if (cut >= total) begin
            e = '{xdv, xpe, xse, xdv ? d : last_good, cyc + 1 + total};
            sb.push_back(e);
            if (xdv) last_good = d;
        end
        for (int t = 1; t < total && t < cut; t++) begin
            @(negedge clk);
            if (chk_ec) begin
                cmp("edge_count", {59'd0, edge_count}, 64'((t - 1) % p));
                cmp("sample_en_busy", {63'd0, data_sample_en}, 64'd1);
            end
            if (t == 2) Prescale = (p == 8) ? 6'd32 : 6'd8;
            RX_IN       = line[t / p];
            sampled_bit = line[(t - 1) / p];
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            RX_IN = 1'b1;
            if (i > 0) sampled_bit = 1'b1;
        end
    endtask

    task automatic check_quiet(input string tag);
        cmp({tag, "_sample_en"}, {63'd0, data_sample_en}, 64'd0);
        cmp({tag, "_edge_count"}, {59'd0, edge_count}, 64'd0);
        cmp({tag, "_bit_count"}, {60'd0, bit_count}, 64'd0);
    endtask

    task automatic check_reset();
        check_quiet("rst");
        cmp("rst_P_DATA", {56'd0, P_DATA}, 64'd0);
        cmp("rst_data_valid", {63'd0, data_valid}, 64'd0);
        cmp("rst_par_err", {63'd0, par_err}, 64'd0);
        cmp("rst_stp_err", {63'd0, stp_err}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
        vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
        vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, !PCHK, PCHK, 1'b0};
        vecs[3] = '{6'd32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1};
        vecs[4] = '{6'd8,  1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
        vecs[5] = '{6'd12, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
        vecs[6] = '{6'd8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0,  PCHK, 1'b1};
        #2 rst = 1'b0;
        #1 check_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(4);
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].pre, vecs[i].pen, vecs[i].ptyp, vecs[i].d, vecs[i].pbit, vecs[i].stop,
                       vecs[i].xdv, vecs[i].xpe, vecs[i].xse, 1000, i == 0);
            idle(3);
            check_quiet("after_frame");
        end
        @(negedge clk);
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        @(negedge clk);
        sampled_bit = 1'b0;
        cmp("glitch_sample_en", {63'd0, data_sample_en}, 64'd1);
        cmp("glitch_edge0", {59'd0, edge_count}, 64'd0);
        repeat (3) @(negedge clk);
        RX_IN = 1'b1;
        @(negedge clk);
        sampled_bit = 1'b1;
        repeat (11) @(negedge clk);
        cmp("glitch_edge15", {59'd0, edge_count}, 64'd15);
        cmp("glitch_busy15", {63'd0, data_sample_en}, 64'd1);
        @(negedge clk);
        check_quiet("glitch_abort");
        idle(2);
        send_frame(6'd8, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1000, 1'b0);
        send_frame(6'd8, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1000, 1'b0);
        idle(3);
        send_frame(6'd16, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4 * 16 + 8, 1'b0);
        #2 rst = 1'b0;
        #1 check_reset();
        last_good = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("no_start_without_edge", {63'd0, data_sample_en}, 64'd0);
        end
        idle(4);
        send_frame(6'd16, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1000, 1'b0);
        idle(4);
        cmp("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, frame data bits per character.
REQ-002 SHALL have port clk  input  1  receiver oversampling clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port RX_IN  input  1  serial line, idle high.
REQ-005 SHALL have port Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port sampled_bit  input  1  majority-voted bit from the data-sampling block, valid at edge_count == P-1.
REQ-009 SHALL have port data_sample_en  output  1  enables the data-sampling block.
REQ-010 SHALL have port edge_count  output  5  oversampling edge index within current bit.
REQ-011 SHALL have port bit_count  output  4  data bit index within frame.
REQ-012 SHALL have port P_DATA  output  DATA_WIDTH  last correctly received character.
REQ-013 SHALL have port data_valid  output  1  one-cycle pulse, new P_DATA.
REQ-014 SHALL have port par_err  output  1  one-cycle pulse, parity mismatch.
REQ-015 SHALL have port stp_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-017 SHALL latch P from Prescale on leaving IDLE; values other than 8/16/32 latch as 16; Prescale changes mid-frame ignored.
REQ-018 IDLE: RX_IN == 0 sampled -> START with edge_count = 0; else remain, edge_count = 0, bit_count = 0.
REQ-019 Outside IDLE, edge_count SHALL increment every clk and wrap P-1 -> 0; data_sample_en = 1 exactly when state != IDLE.
REQ-020 START at edge_count == P-1: sampled_bit == 1 (glitch) -> IDLE, no error pulse; sampled_bit == 0 -> DATA, bit_count = 0.
REQ-021 DATA at edge_count == P-1: shift sampled_bit into shift register LSB-first (shift right, new bit at MSB), bit_count++; after bit DATA_WIDTH-1 -> PARITY if latched PAR_EN else STOP.
REQ-022 PAR_EN and PAR_TYP SHALL be latched with Prescale at frame start.
REQ-023 PARITY at edge_count == P-1: internal parity-fail flag = (XOR of shift register ^ PAR_TYP) != sampled_bit; -> STOP.
REQ-024 STOP at edge_count == P-1: -> IDLE; next cycle pulse stp_err = ~sampled_bit, par_err = parity-fail flag.
REQ-025 Same cycle as REQ-024 pulses, data_valid SHALL pulse and P_DATA update only if neither error; otherwise P_DATA holds.
REQ-026 Back-to-back frames: RX_IN low in the first IDLE cycle after STOP SHALL start a new frame with no lost cycle.
REQ-027 data_valid, par_err, stp_err SHALL never be high longer than one cycle.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, edge_count = 0, bit_count = 0, P_DATA = 0, data_valid = par_err = stp_err = 0, data_sample_en = 0, shift register and latched config cleared.
REQ-029 Reset mid-frame SHALL discard the partial character with no output pulse; first frame after release requires a fresh falling edge.

Configuration
REQ-030 With PARITY_CHECK_EN defined, PARITY state and par_err behave as above.
REQ-031 Without PARITY_CHECK_EN, PARITY state SHALL not exist, PAR_EN/PAR_TYP ignored, DATA -> STOP always, par_err tied 0.

Verification
REQ-032 P=8, PAR_EN=0, frame 0xA5 with valid stop -> data_valid one pulse, P_DATA = 0xA5, no error pulses, 80 clk after falling edge.
REQ-033 P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 -> P_DATA = 0x3C; repeat with parity 1 -> par_err pulse, P_DATA stays 0x3C, no data_valid.
REQ-034 P=32, 0x55 with stop bit 0 -> stp_err pulse, no data_valid, return to IDLE.
REQ-035 P=16, RX_IN low 4 clk then high -> START aborts at edge 15, no pulses, data_sample_en low after.
REQ-036 P=8, two back-to-back frames 0x01, 0xFE -> two data_valid pulses 80 clk apart, P_DATA 0x01 then 0xFE.
REQ-037 rst asserted during DATA bit 3 -> all outputs zero immediately; next frame 0x7E received correctly.
